// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_arbiter
// Purpose  : Two-requester round-robin front end for one shared pipelined
//            IEEE-754 single-precision adder. One pair is in flight at a time.
//            The result is held for the owning requester until it is taken.
// Ports    : clk, reset (async, active low)
//            req0/req1 : valid/ready handshake with operands a, b (32b)
//            resp0/resp1 : valid/ready handshake with data (32b) and ovf
//            add_in1/add_in2/add_enable : registered drive to the adder
//            add_out/add_overflow : adder results
// Options  : FP_ARB_ZERO_BYPASS_EN - pairs with a +/-0 operand bypass the
//            adder and produce their result after one capture cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  output logic        resp0_ovf,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  output logic        resp1_ovf,
  input  logic        resp1_ready,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  output logic        add_enable,
  input  logic [31:0] add_out,
  input  logic        add_overflow
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;
  localparam logic [3:0] c_cnt_last = 4'(LATENCY - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last_grant;
  logic        r_bypass;
  logic [31:0] r_add_in1;
  logic [31:0] r_add_in2;
  logic        r_add_enable;
  logic [31:0] r_resp0_data;
  logic [31:0] r_resp1_data;
  logic        r_resp0_ovf;
  logic        r_resp1_ovf;

  logic        w_any_valid;
  logic        w_grant;
  logic        w_accept;
  logic        w_done;
  logic        w_resp_take;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic        w_bypass_hit;
  logic [31:0] w_cap_data;
  logic        w_cap_ovf;

  // Round robin: under contention the requester not served last wins;
  // a lone requester always wins.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept    = (r_state == c_st_idle) & w_any_valid;
  assign w_sel_a     = w_grant ? req1_a : req0_a;
  assign w_sel_b     = w_grant ? req1_b : req0_b;
  assign w_done      = (r_state == c_st_run) & (r_bypass | (r_cnt == c_cnt_last));
  assign w_resp_take = (r_state == c_st_resp) & (r_owner ? resp1_ready : resp0_ready);

`ifdef FP_ARB_ZERO_BYPASS_EN
  logic        w_in1_zero;
  logic        w_in2_zero;
  logic [31:0] w_byp_data;

  // Decided on the incoming pair so the adder is never enabled for it.
  assign w_bypass_hit = (w_sel_a[30:0] == 31'd0) | (w_sel_b[30:0] == 31'd0);
  assign w_in1_zero   = (r_add_in1[30:0] == 31'd0);
  assign w_in2_zero   = (r_add_in2[30:0] == 31'd0);

  // Zero plus zero is -0 only when both are -0 (round-to-nearest rule).
  always_comb begin
    if (w_in1_zero && w_in2_zero) begin
      w_byp_data = {r_add_in1[31] & r_add_in2[31], 31'd0};
    end else if (w_in1_zero) begin
      w_byp_data = r_add_in2;
    end else begin
      w_byp_data = r_add_in1;
    end
  end

  assign w_cap_data = r_bypass ? w_byp_data : add_out;
  assign w_cap_ovf  = r_bypass ? (w_byp_data[30:23] == 8'hFF) : add_overflow;
`else
  assign w_bypass_hit = 1'b0;
  assign w_cap_data   = add_out;
  assign w_cap_ovf    = add_overflow;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept)    w_next_state = c_st_run;
      c_st_run:  if (w_done)      w_next_state = c_st_resp;
      c_st_resp: if (w_resp_take) w_next_state = c_st_idle;
      default:                    w_next_state = c_st_idle;
    endcase
  end

  // Outputs. Ready is gated by reset so it reads 0 while reset is held
  // even though the state register already sits in IDLE.
  always_comb begin
    req0_ready  = reset & w_accept & ~w_grant;
    req1_ready  = reset & w_accept &  w_grant;
    resp0_valid = (r_state == c_st_resp) & ~r_owner;
    resp1_valid = (r_state == c_st_resp) &  r_owner;
  end

  assign add_in1    = r_add_in1;
  assign add_in2    = r_add_in2;
  assign add_enable = r_add_enable;
  assign resp0_data = r_resp0_data;
  assign resp0_ovf  = r_resp0_ovf;
  assign resp1_data = r_resp1_data;
  assign resp1_ovf  = r_resp1_ovf;

  // Datapath and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_bypass     <= 1'b0;
      r_add_in1    <= 32'd0;
      r_add_in2    <= 32'd0;
      r_add_enable <= 1'b0;
      r_resp0_data <= 32'd0;
      r_resp1_data <= 32'd0;
      r_resp0_ovf  <= 1'b0;
      r_resp1_ovf  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_add_in1    <= w_sel_a;
            r_add_in2    <= w_sel_b;
            r_owner      <= w_grant;
            r_cnt        <= 4'd0;
            r_bypass     <= w_bypass_hit;
            r_add_enable <= ~w_bypass_hit;
          end
        end
        c_st_run: begin
          if (w_done) begin
            r_add_enable <= 1'b0;
            if (r_owner) begin
              r_resp1_data <= w_cap_data;
              r_resp1_ovf  <= w_cap_ovf;
            end else begin
              r_resp0_data <= w_cap_data;
              r_resp0_ovf  <= w_cap_ovf;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_st_resp: begin
          if (w_resp_take) begin
            r_last_grant <= r_owner;
          end
        end
        default: begin
          r_add_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_arbiter
// Purpose  : Self-checking bench for fp_add_arbiter. Models the shared adder
//            with real arithmetic and predicts grants, results and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_ovf, resp1_ovf;
  logic        resp0_ready, resp1_ready;
  logic [31:0] add_in1, add_in2, add_out;
  logic        add_enable, add_overflow;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int en_total = 0;
  int unstable = 0;
  int en_run   = 0;
  bit exp_last;
  logic        prev_en = 1'b0;
  logic [63:0] prev_ops = 64'd0;
  logic [31:0] model_sum;

  fp_add_arbiter #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ovf(resp0_ovf), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ovf(resp1_ovf), .resp1_ready(resp1_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_enable(add_enable),
    .add_out(add_out), .add_overflow(add_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural single-precision arithmetic ----------------
  function automatic real sp2real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'hFF)      d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else if (f[30:23] == 8'h00) d = {f[31], 63'd0};
    else                        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return {d[63], 8'hFF, d[51:29]};
    e = e - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)    return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 154));
    return r;
  endfunction

  // ---------------- shared adder model and monitors ----------------
  // Result is valid once enable has been high for LATENCY cycles
  // (the current cycle included); otherwise it drives junk.
  always @(posedge clk or negedge reset) begin
    if (!reset)          en_run <= 0;
    else if (add_enable) en_run <= en_run + 1;
    else                 en_run <= 0;
  end
  always_comb model_sum = fp_sum(add_in1, add_in2);
  assign add_out      = (add_enable && en_run >= LATENCY - 1) ? model_sum : 32'hDEADBEEF;
  assign add_overflow = (add_enable && en_run >= LATENCY - 1) ? (model_sum[30:23] == 8'hFF) : 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (add_enable) en_total <= en_total + 1;
  always @(posedge clk) begin
    if (add_enable && prev_en && ({add_in1, add_in2} !== prev_ops)) unstable <= unstable + 1;
    prev_en  <= add_enable;
    prev_ops <= {add_in1, add_in2};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns the cycle number of the handshake, -1 on timeout; ends just
  // after the accepting edge.
  task automatic wait_accept(input int id, input int limit, output int at_cyc);
    bit found;
    found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < limit && !found; i++) begin
      #1;
      if ((id == 0 && req0_valid && req0_ready) || (id == 1 && req1_valid && req1_ready)) begin
        at_cyc = cyc;
        found = 1'b1;
      end
      tick();
    end
  endtask

  // Returns the first cycle the response is visible, -1 on timeout;
  // stays in that cycle.
  task automatic wait_resp(input int id, input int limit, output int at_cyc);
    bit found;
    found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < limit && !found; i++) begin
      #1;
      if ((id == 0 && resp0_valid) || (id == 1 && resp1_valid)) begin
        at_cyc = cyc;
        found = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic take(input int id);
    if (id == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = rnd_fp(); req0_b = rnd_fp(); req1_a = rnd_fp(); req1_b = rnd_fp();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #3;
    total++;
    if ({add_enable, add_in1, add_in2, resp0_valid, resp0_data, resp0_ovf, resp1_valid, resp1_data, resp1_ovf} !== '0) begin
      $display("FAIL reset_outputs: got en=%b in1=%h in2=%h v0=%b d0=%h v1=%b d1=%h, required all 0",
               add_enable, add_in1, add_in2, resp0_valid, resp0_data, resp1_valid, resp1_data);
    end else passed++;
    total++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      $display("FAIL reset_ready: got %b required 00", {req1_ready, req0_ready});
    end else passed++;
    tick(); tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    exp_last = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int acc, rsp, en0;
    en0 = en_total;
    req0_a = 32'h3FC00000; req0_b = 32'hC0B00000; req0_valid = 1'b1;
    wait_accept(0, 10, acc);
    req0_valid = 1'b0;
    wait_resp(0, 40, rsp);
    total++;
    if (acc < 0 || rsp - acc != LATENCY + 1) $display("FAIL basic_latency: got %0d required %0d", rsp - acc, LATENCY + 1);
    else passed++;
    total++;
    if ({resp0_data, resp0_ovf} !== {32'hC0800000, 1'b0})
      $display("FAIL basic_data: got %h/%b required c0800000/0", resp0_data, resp0_ovf);
    else passed++;
    total++;
    if (resp1_valid !== 1'b0) $display("FAIL basic_other_valid: got %b required 0", resp1_valid);
    else passed++;
    total++;
    if (en_total - en0 != LATENCY) $display("FAIL basic_enable_cycles: got %0d required %0d", en_total - en0, LATENCY);
    else passed++;
    take(0);
    exp_last = 1'b0;
    #1;
    total++;
    if (resp0_valid !== 1'b0) $display("FAIL basic_resp_cleared: got %b required 0", resp0_valid);
    else passed++;
  endtask

  task automatic test_contention();
    int acc0, acc1, rsp0, rsp1, w;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    exp_last = 1'b1;
    req0_a = 32'h3FA00000; req0_b = 32'h40200000;
    req1_a = 32'hBFA00000; req1_b = 32'hC0200000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b1;
    w = exp_last ? 0 : 1;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== (w == 1 ? 2'b10 : 2'b01))
      $display("FAIL contention_grant: got %b required %b", {req1_ready, req0_ready}, (w == 1 ? 2'b10 : 2'b01));
    else passed++;
    wait_accept(0, 5, acc0);
    req0_valid = 1'b0;
    wait_resp(0, 40, rsp0);
    total++;
    if ({resp0_data, resp0_ovf} !== {32'h40700000, 1'b0})
      $display("FAIL contention_data0: got %h/%b required 40700000/0", resp0_data, resp0_ovf);
    else passed++;
    exp_last = 1'b0;
    wait_accept(1, 10, acc1);
    resp0_ready = 1'b0;
    req1_valid = 1'b0;
    total++;
    if (acc0 < 0 || acc1 < 0 || acc1 - acc0 != LATENCY + 2)
      $display("FAIL contention_spacing: got %0d required %0d", acc1 - acc0, LATENCY + 2);
    else passed++;
    wait_resp(1, 40, rsp1);
    total++;
    if ({resp1_data, resp1_ovf} !== {32'hC0700000, 1'b0})
      $display("FAIL contention_data1: got %h/%b required c0700000/0", resp1_data, resp1_ovf);
    else passed++;
    total++;
    if (rsp1 < 0 || rsp1 - acc1 != LATENCY + 1) $display("FAIL contention_latency1: got %0d required %0d", rsp1 - acc1, LATENCY + 1);
    else passed++;
    take(1);
    exp_last = 1'b1;
  endtask

  task automatic test_overflow();
    int acc, rsp;
    req1_a = 32'h7F800000; req1_b = 32'h3F800000; req1_valid = 1'b1;
    wait_accept(1, 10, acc);
    req1_valid = 1'b0;
    wait_resp(1, 40, rsp);
    total++;
    if ({resp1_data, resp1_ovf} !== {32'h7F800000, 1'b1})
      $display("FAIL overflow_data: got %h/%b required 7f800000/1", resp1_data, resp1_ovf);
    else passed++;
    total++;
    if (resp0_valid !== 1'b0) $display("FAIL overflow_other_valid: got %b required 0", resp0_valid);
    else passed++;
    take(1);
    exp_last = 1'b1;
  endtask

  task automatic test_hold();
    int acc, rsp, acc1, rsp1;
    logic [31:0] e0, e1;
    req0_a = rnd_fp(); req0_b = rnd_fp(); req0_valid = 1'b1;
    e0 = fp_sum(req0_a, req0_b);
    wait_accept(0, 10, acc);
    req0_valid = 1'b0;
    req1_a = rnd_fp(); req1_b = rnd_fp(); req1_valid = 1'b1;
    e1 = fp_sum(req1_a, req1_b);
    resp1_ready = 1'b1;  // non-owner ready must be ignored
    wait_resp(0, 40, rsp);
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({resp0_valid, resp0_data, resp0_ovf, req1_ready, resp1_valid} !== {1'b1, e0, 1'b0, 1'b0, 1'b0})
        $display("FAIL hold_cycle%0d: got v0=%b d0=%h o0=%b rdy1=%b v1=%b required 1/%h/0/0/0",
                 i, resp0_valid, resp0_data, resp0_ovf, req1_ready, resp1_valid, e0);
      else passed++;
      tick();
    end
    resp1_ready = 1'b0;
    take(0);
    exp_last = 1'b0;
    wait_accept(1, 10, acc1);
    req1_valid = 1'b0;
    total++;
    if (acc1 < 0) $display("FAIL hold_waiting_req_lost: got no accept required accept");
    else passed++;
    wait_resp(1, 40, rsp1);
    total++;
    if (resp1_data !== e1) $display("FAIL hold_req1_data: got %h required %h", resp1_data, e1);
    else passed++;
    take(1);
    exp_last = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int acc, seen, rsp;
    logic [31:0] e0;
    req1_a = rnd_fp(); req1_b = rnd_fp(); req1_valid = 1'b1;
    wait_accept(1, 10, acc);
    req1_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({add_enable, add_in1, add_in2, resp0_valid, resp0_data, resp0_ovf, resp1_valid, resp1_data, resp1_ovf, req0_ready, req1_ready} !== '0)
      $display("FAIL midrun_reset_outputs: got en=%b in1=%h in2=%h v1=%b d1=%h, required all 0",
               add_enable, add_in1, add_in2, resp1_valid, resp1_data);
    else passed++;
    tick(); tick();
    reset = 1'b1;
    exp_last = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp0_valid || resp1_valid || add_enable) seen++;
      tick();
    end
    total++;
    if (seen != 0) $display("FAIL midrun_stale_activity: got %0d active cycles required 0", seen);
    else passed++;
    req0_a = rnd_fp(); req0_b = rnd_fp(); req1_a = rnd_fp(); req1_b = rnd_fp();
    req0_valid = 1'b1; req1_valid = 1'b1;
    e0 = fp_sum(req0_a, req0_b);
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL midrun_first_grant: got %b required 01", {req1_ready, req0_ready});
    else passed++;
    wait_accept(0, 5, acc);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(0, 40, rsp);
    total++;
    if (resp0_data !== e0) $display("FAIL midrun_after_data: got %h required %h", resp0_data, e0);
    else passed++;
    take(0);
    exp_last = 1'b0;
  endtask

  task automatic test_zero_operand();
    int acc, rsp, en0, elat, een;
    logic [31:0] a, b, e;
    logic eo;
`ifdef FP_ARB_ZERO_BYPASS_EN
    elat = 2; een = 0;
`else
    elat = LATENCY + 1; een = LATENCY;
`endif
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin a = 32'h00000000; b = 32'h3F99999A; e = 32'h3F99999A; eo = 1'b0; end
        1:       begin a = 32'h80000000; b = 32'h80000000; e = 32'h80000000; eo = 1'b0; end
        default: begin a = 32'h7F800000; b = 32'h80000000; e = 32'h7F800000; eo = 1'b1; end
      endcase
      en0 = en_total;
      req0_a = a; req0_b = b; req0_valid = 1'b1;
      wait_accept(0, 10, acc);
      req0_valid = 1'b0;
      wait_resp(0, 40, rsp);
      total++;
      if (acc < 0 || rsp - acc != elat) $display("FAIL zero%0d_latency: got %0d required %0d", k, rsp - acc, elat);
      else passed++;
      total++;
      if (resp0_data !== e) $display("FAIL zero%0d_data: got %h required %h", k, resp0_data, e);
      else passed++;
      total++;
      if (resp0_ovf !== eo) $display("FAIL zero%0d_ovf: got %b required %b", k, resp0_ovf, eo);
      else passed++;
      total++;
      if (en_total - en0 != een) $display("FAIL zero%0d_enable_cycles: got %0d required %0d", k, en_total - en0, een);
      else passed++;
      take(0);
      exp_last = 1'b0;
    end
  endtask

  task automatic test_random();
    int sel, w, acc, rsp, d;
    logic [31:0] e;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(1, 3);
      req0_a = rnd_fp(); req0_b = rnd_fp(); req1_a = rnd_fp(); req1_b = rnd_fp();
      req0_valid = sel[0]; req1_valid = sel[1];
      w = (sel == 3) ? (exp_last ? 0 : 1) : (sel == 2 ? 1 : 0);
      e = (w == 1) ? fp_sum(req1_a, req1_b) : fp_sum(req0_a, req0_b);
      #1;
      total++;
      if ({req1_ready, req0_ready} !== (w == 1 ? 2'b10 : 2'b01))
        $display("FAIL rand%0d_grant: got %b required %b", it, {req1_ready, req0_ready}, (w == 1 ? 2'b10 : 2'b01));
      else passed++;
      wait_accept(w, 5, acc);
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_resp(w, 40, rsp);
      total++;
      if (acc < 0 || rsp - acc != LATENCY + 1 ||
          ((w == 1) ? {resp1_data, resp1_ovf} : {resp0_data, resp0_ovf}) !== {e, 1'b0})
        $display("FAIL rand%0d_result: got lat=%0d data=%h required lat=%0d data=%h", it, rsp - acc,
                 (w == 1) ? resp1_data : resp0_data, LATENCY + 1, e);
      else passed++;
      d = $urandom_range(0, 3);
      repeat (d) tick();
      take(w);
      exp_last = w[0];
    end
    total++;
    if (unstable != 0) $display("FAIL operand_stability: got %0d changes required 0", unstable);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_overflow();
    test_hold();
    test_reset_mid_run();
    test_zero_operand();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
